// File: rtl/decode_pkg.sv
// Shared types and helpers for the RV32I decode stage: opcodes, ALU/result/immediate
// selectors, the bundled control word, and the immediate/ALU-op decode functions.
package decode_pkg;

  typedef logic [6:0] opcode_t;

  localparam opcode_t OPC_OP     = 7'h33;
  localparam opcode_t OPC_OP_IMM = 7'h13;
  localparam opcode_t OPC_LOAD   = 7'h03;
  localparam opcode_t OPC_STORE  = 7'h23;
  localparam opcode_t OPC_BRANCH = 7'h63;
  localparam opcode_t OPC_JAL    = 7'h6F;
  localparam opcode_t OPC_JALR   = 7'h67;
  localparam opcode_t OPC_LUI    = 7'h37;
  localparam opcode_t OPC_AUIPC  = 7'h17;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [1:0] {RES_ALU, RES_MEM, RES_PC4} result_src_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_R} imm_type_t;

  typedef struct packed {
    alu_op_t     alu_op;
    logic        alu_src;
    result_src_t result_src;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = ctrl_t'('0);

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_t kind);
    case (kind)
      IMM_I:   return {{20{instr[31]}}, instr[31:20]};
      IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   return {instr[31:12], 12'b0};
      IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

  // instr[30] selects SUB only for register-register ops; it selects SRA for both forms.
  function automatic alu_op_t arith_op(input logic [2:0] funct3, input logic alt,
                                       input logic is_reg);
    case (funct3)
      3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/stage_decode_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous write port,
// x0 hardwired to zero, and write-first bypass so writeback data is visible in the same cycle.
module stage_decode_regfile
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [XLEN-1:0] wr_data_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o
);

  logic [XLEN-1:0] regs_q [NUM_REGS];
  logic            wr_live;

  assign wr_live = wr_en_i && (wr_addr_i != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wr_live) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    rs1_data_o = '0;
    rs2_data_o = '0;
    if (rs1_addr_i != '0) rs1_data_o = (wr_live && wr_addr_i == rs1_addr_i) ? wr_data_i
                                                                           : regs_q[rs1_addr_i];
    if (rs2_addr_i != '0) rs2_data_o = (wr_live && wr_addr_i == rs2_addr_i) ? wr_data_i
                                                                           : regs_q[rs2_addr_i];
  end

endmodule

// File: rtl/stage_decode.sv
// RV32I decode stage: register-file read, immediate generation and control decode,
// all captured in the decode/execute pipeline register.
module stage_decode
  import decode_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_decode,
  input  logic [31:0]     fetch_instr,
  input  logic [XLEN-1:0] fetch_instr_addr,
  input  logic [XLEN-1:0] fetch_instr_addr_plus,
  input  logic            wb_reg_write,
  input  logic [RW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] decode_instr_addr,
  output logic [XLEN-1:0] decode_instr_addr_plus,
  output logic [XLEN-1:0] decode_rs1_data,
  output logic [XLEN-1:0] decode_rs2_data,
  output logic [RW-1:0]   decode_rs1,
  output logic [RW-1:0]   decode_rs2,
  output logic [RW-1:0]   decode_rd,
  output logic [XLEN-1:0] decode_imm,
  output logic [2:0]      decode_funct3,
  output logic [3:0]      decode_alu_op,
  output logic            decode_alu_src,
  output logic [1:0]      decode_result_src,
  output logic            decode_reg_write,
  output logic            decode_mem_read,
  output logic            decode_mem_write,
  output logic            decode_branch,
  output logic            decode_jal,
  output logic            decode_jalr,
  output logic            decode_illegal
);

  opcode_t         opcode;
  logic [2:0]      funct3;
  logic [RW-1:0]   rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rf_rs1, rf_rs2;
  imm_type_t       imm_type;
  ctrl_t           ctrl_d, ctrl_q;
  logic [XLEN-1:0] imm_d, rs1_data_d;
  logic [XLEN-1:0] pc_q, pc4_q, rs1_data_q, rs2_data_q, imm_q;
  logic [RW-1:0]   rs1_q, rs2_q, rd_q;
  logic [2:0]      funct3_q;

  assign opcode  = fetch_instr[6:0];
  assign funct3  = fetch_instr[14:12];
  assign rd_idx  = fetch_instr[11:7];
  assign rs1_idx = fetch_instr[19:15];
  assign rs2_idx = fetch_instr[24:20];

  stage_decode_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wb_reg_write),
    .wr_addr_i  (wb_rd),
    .wr_data_i  (wb_data),
    .rs1_addr_i (rs1_idx),
    .rs2_addr_i (rs2_idx),
    .rs1_data_o (rf_rs1),
    .rs2_data_o (rf_rs2)
  );

  // An all-zero word is the fetch bubble, so opcode 0 falls to default without flagging illegal.
  always_comb begin
    ctrl_d   = CTRL_NOP;
    imm_type = IMM_R;
    case (opcode)
      OPC_OP: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = arith_op(funct3, fetch_instr[30], 1'b1);
      end
      OPC_OP_IMM: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_op    = arith_op(funct3, fetch_instr[30], 1'b0);
        imm_type         = IMM_I;
      end
      OPC_LOAD: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_MEM;
        imm_type          = IMM_I;
      end
      OPC_STORE: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_type         = IMM_S;
      end
      OPC_BRANCH: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.alu_op = ALU_SUB;
        imm_type      = IMM_B;
      end
      OPC_JAL: begin
        ctrl_d.jal        = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.result_src = RES_PC4;
        imm_type          = IMM_J;
      end
      OPC_JALR: begin
        ctrl_d.jalr       = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_PC4;
        imm_type          = IMM_I;
      end
      OPC_LUI: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.alu_op    = ALU_PASS_B;
        imm_type         = IMM_U;
      end
      OPC_AUIPC: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_type         = IMM_U;
      end
      default: ctrl_d.illegal = (fetch_instr != '0);
    endcase
  end

  assign imm_d = gen_imm(fetch_instr, imm_type);
  // AUIPC adds to the PC, so the PC is handed to execute as operand A.
  assign rs1_data_d = (opcode == OPC_AUIPC) ? fetch_instr_addr : rf_rs1;

  always_ff @(posedge clk) begin
    if (rst || flush_decode) begin
      pc_q       <= '0;
      pc4_q      <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      funct3_q   <= '0;
      ctrl_q     <= CTRL_NOP;
    end else begin
      pc_q       <= fetch_instr_addr;
      pc4_q      <= fetch_instr_addr_plus;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rf_rs2;
      rs1_q      <= rs1_idx;
      rs2_q      <= rs2_idx;
      rd_q       <= rd_idx;
      imm_q      <= imm_d;
      funct3_q   <= funct3;
      ctrl_q     <= ctrl_d;
    end
  end

  assign decode_instr_addr      = pc_q;
  assign decode_instr_addr_plus = pc4_q;
  assign decode_rs1_data        = rs1_data_q;
  assign decode_rs2_data        = rs2_data_q;
  assign decode_rs1             = rs1_q;
  assign decode_rs2             = rs2_q;
  assign decode_rd              = rd_q;
  assign decode_imm             = imm_q;
  assign decode_funct3          = funct3_q;
  assign decode_alu_op          = ctrl_q.alu_op;
  assign decode_alu_src         = ctrl_q.alu_src;
  assign decode_result_src      = ctrl_q.result_src;
  assign decode_reg_write       = ctrl_q.reg_write;
  assign decode_mem_read        = ctrl_q.mem_read;
  assign decode_mem_write       = ctrl_q.mem_write;
  assign decode_branch          = ctrl_q.branch;
  assign decode_jal             = ctrl_q.jal;
  assign decode_jalr            = ctrl_q.jalr;
  assign decode_illegal         = ctrl_q.illegal;

endmodule
